// File: rtl/ui5640cfg_seq.sv
// OV5640 register-table sequencer.
// Walks the table one 24-bit entry {addr[15:0], data[7:0]} at a time and issues one SCCB
// write request per entry to the downstream byte master. Inserts the post-software-reset wait
// after a 0x3008 write with bit 7 set and retries NACKed writes up to MAX_RETRY extra times.
// Optional build macro UI5640_CFG_ERRCNT_EN adds a saturating NACK counter and the index of
// the most recent NACK.
module ui5640cfg_seq #(
  parameter int unsigned CLK_MHZ    = 25,
  parameter int unsigned RST_DLY_US = 5000,
  parameter logic [7:0]  DEV_ADDR   = 8'h78,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic [8:0]  reg_index_o,
  input  logic [31:0] reg_data_i,
  input  logic [8:0]  reg_size_i,
  output logic        wr_req_o,
  input  logic        wr_ack_i,
  input  logic        wr_done_i,
  input  logic        wr_err_i,
  output logic [7:0]  wr_dev_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o,
  output logic        done_o,
`ifdef UI5640_CFG_ERRCNT_EN
  output logic        err_o,
  output logic [15:0] nack_cnt_o,
  output logic [8:0]  last_err_idx_o
`else
  output logic        err_o
`endif
);

  localparam int unsigned RetryW    = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] MaxRetry = RetryW'(MAX_RETRY);
  localparam logic [31:0] DlyCycles = 32'(CLK_MHZ * RST_DLY_US);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StReq,
    StWait,
    StDelay,
    StNext,
    StDone,
    StErr
  } state_e;

  state_e             state_q, state_d;
  logic [8:0]         size_q, size_d;
  logic [8:0]         index_q, index_d;
  logic [15:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic [31:0]        dly_q, dly_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               start_pass;
  logic               nack_seen;

  // Table entries only carry 24 bits; the top byte is don't-care.
  logic unused_data_hi;
  assign unused_data_hi = ^reg_data_i[31:24];

  assign start_pass = (state_q == StIdle) && start_i;
  assign nack_seen  = (state_q == StWait) && wr_done_i && wr_err_i;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    index_d = index_q;
    addr_d  = addr_q;
    data_d  = data_q;
    retry_d = retry_q;
    dly_d   = dly_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          size_d  = reg_size_i;
          index_d = 9'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          retry_d = '0;
          if (reg_size_i == 9'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        addr_d  = reg_data_i[23:8];
        data_d  = reg_data_i[7:0];
        state_d = StReq;
      end
      StReq: begin
        // An ack that coincides with a done counts as ack only.
        if (wr_ack_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (wr_done_i) begin
          if (!wr_err_i) begin
            // Software reset (0x3008 bit 7) needs the sensor to settle before the next write.
            if (addr_q == 16'h3008 && data_q[7]) begin
              state_d = StDelay;
              dly_d   = 32'd0;
            end else begin
              state_d = StNext;
            end
          end else if (retry_q < MaxRetry) begin
            retry_d = retry_q + 1'b1;
            state_d = StReq;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StDelay: begin
        dly_d = dly_q + 32'd1;
        if (dly_d >= DlyCycles) begin
          state_d = StNext;
        end
      end
      StNext: begin
        retry_d = '0;
        if (index_q == size_q - 9'd1) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          index_d = index_q + 9'd1;
          state_d = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StErr: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
      size_q  <= 9'd0;
      index_q <= 9'd0;
      addr_q  <= 16'd0;
      data_q  <= 8'd0;
      retry_q <= '0;
      dly_q   <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      dly_q   <= dly_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state so wr_req_o drops as soon as reset asserts.
  always_comb begin
    wr_req_o    = (state_q == StReq);
    busy_o      = !(state_q inside {StIdle, StDone, StErr});
    reg_index_o = index_q;
    wr_dev_o    = DEV_ADDR;
    wr_addr_o   = addr_q;
    wr_data_o   = data_q;
    done_o      = done_q;
    err_o       = err_q;
  end

`ifdef UI5640_CFG_ERRCNT_EN
  logic [15:0] nack_cnt_q, nack_cnt_d;
  logic [8:0]  last_err_idx_q, last_err_idx_d;

  // NACK statistics: counter restarts with each pass, last index persists across passes.
  always_comb begin
    nack_cnt_d     = nack_cnt_q;
    last_err_idx_d = last_err_idx_q;
    if (start_pass) begin
      nack_cnt_d = 16'd0;
    end else if (nack_seen) begin
      if (nack_cnt_q != 16'hFFFF) begin
        nack_cnt_d = nack_cnt_q + 16'd1;
      end
      last_err_idx_d = index_q;
    end
  end

  // NACK statistics registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      nack_cnt_q     <= 16'd0;
      last_err_idx_q <= 9'd0;
    end else begin
      nack_cnt_q     <= nack_cnt_d;
      last_err_idx_q <= last_err_idx_d;
    end
  end

  assign nack_cnt_o     = nack_cnt_q;
  assign last_err_idx_o = last_err_idx_q;
`else
  logic unused_stats;
  assign unused_stats = start_pass ^ nack_seen;
`endif

endmodule

// File: tb/tb_ui5640cfg_seq.sv
// Scoreboard bench for ui5640cfg_seq: a bench-side SCCB master answers requests with fixed
// ack/done latencies and a per-transaction NACK plan; a monitor checks each request against the
// expected-write queue filled by the stimulus. Reset wait shortened to 100 cycles.
module tb_ui5640cfg_seq;

  localparam int DlyN    = 100;  // CLK_MHZ 25 * RST_DLY_US 4
  localparam int AckLat  = 2;
  localparam int DoneLat = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  reg_index;
  logic [31:0] reg_data;
  logic [8:0]  reg_size = 9'd0;
  logic        wr_req;
  logic        wr_ack = 1'b0;
  logic        wr_done = 1'b0;
  logic        wr_err = 1'b0;
  logic [7:0]  wr_dev;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err;
`ifdef UI5640_CFG_ERRCNT_EN
  logic [15:0] nack_cnt;
  logic [8:0]  last_err_idx;
`endif

  ui5640cfg_seq #(
    .CLK_MHZ   (25),
    .RST_DLY_US(4),
    .DEV_ADDR  (8'h78),
    .MAX_RETRY (3)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .start_i    (start),
    .reg_index_o(reg_index),
    .reg_data_i (reg_data),
    .reg_size_i (reg_size),
    .wr_req_o   (wr_req),
    .wr_ack_i   (wr_ack),
    .wr_done_i  (wr_done),
    .wr_err_i   (wr_err),
    .wr_dev_o   (wr_dev),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .busy_o     (busy),
    .done_o     (done),
`ifdef UI5640_CFG_ERRCNT_EN
    .err_o         (err),
    .nack_cnt_o    (nack_cnt),
    .last_err_idx_o(last_err_idx)
`else
    .err_o      (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] tbl [0:511];
  assign reg_data = {8'hA5, tbl[reg_index]};

  logic [23:0] exp_q[$];
  logic        nack_plan[$];
  int          req_cyc[$];
  int          done_cyc[$];
  int          req_cnt = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bench SCCB master: ack AckLat cycles after request, done DoneLat cycles after ack.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0;
      wr_done = 1'b0;
      wr_err = 1'b0;
      if (!rstn) begin
        phase = 0;
      end else begin
        case (phase)
          0: if (wr_req) begin phase = 1; cnt = 1; end
          1: begin
            if (!wr_req) phase = 0;
            else begin
              cnt++;
              if (cnt == AckLat) begin wr_ack = 1'b1; phase = 2; cnt = 0; end
            end
          end
          default: begin
            cnt++;
            if (cnt == DoneLat) begin
              wr_done = 1'b1;
              wr_err = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
              done_cyc.push_back(cyc);
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: every new request is compared against the head of the expected queue.
  initial begin
    logic prev;
    logic [23:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_req && !prev) begin
        req_cnt++;
        req_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=%0h required=none", {wr_addr, wr_data});
        end else begin
          e = exp_q.pop_front();
          check("req_entry", {8'h0, wr_dev, wr_addr, wr_data}, {8'h0, 8'h78, e});
        end
      end
      prev = wr_req;
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    nack_plan.delete();
    req_cyc.delete();
    done_cyc.delete();
    req_cnt = 0;
  endtask

  task automatic push_all();
    exp_q.push_back(24'h310311);
    exp_q.push_back(24'h300882);
    exp_q.push_back(24'h300842);
    exp_q.push_back(24'h310303);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output int at);
    int n;
    n = 0;
    at = -1;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done || err) at = cyc;
    else begin
      checks++;
      failures++;
      $display("FAIL pass_timeout actual=busy required=done_or_err");
    end
  endtask

  initial begin
    int t;
    int n;
    for (int i = 0; i < 512; i++) tbl[i] = 24'h0;
    tbl[0] = 24'h310311;
    tbl[1] = 24'h300882;
    tbl[2] = 24'h300842;
    tbl[3] = 24'h310303;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_req", 32'(wr_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_index", 32'(reg_index), 32'd0);
    check("rst_addr_data", {8'h0, wr_addr, wr_data}, 32'd0);
    check("rst_dev", 32'(wr_dev), 32'h78);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Clean 4-entry pass with software-reset wait after entry 1.
    clear_logs();
    push_all();
    reg_size = 9'd4;
    pulse_start();
    wait_end(2000, t);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_req_cnt", 32'(req_cnt), 32'd4);
    check("t1_exp_left", 32'(exp_q.size()), 32'd0);
    check("t1_delay_gap", 32'(req_cyc[2] - done_cyc[1]), 32'(DlyN + 3));
    check("t1_plain_gap", 32'(req_cyc[3] - done_cyc[2]), 32'd3);
    check("t1_done_lat", 32'(t - done_cyc[3]), 32'd2);
    check("t1_index", 32'(reg_index), 32'd3);

    // Entry 2 NACKed twice then accepted.
    clear_logs();
    push_all();
    exp_q.insert(2, 24'h300842);
    exp_q.insert(2, 24'h300842);
    nack_plan = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    pulse_start();
    wait_end(2000, t);
    check("t2_done", 32'(done), 32'd1);
    check("t2_err", 32'(err), 32'd0);
    check("t2_req_cnt", 32'(req_cnt), 32'd6);
    check("t2_exp_left", 32'(exp_q.size()), 32'd0);
`ifdef UI5640_CFG_ERRCNT_EN
    check("t2_nack_cnt", 32'(nack_cnt), 32'd2);
    check("t2_last_err_idx", 32'(last_err_idx), 32'd2);
`endif

    // Entry 1 NACKed on every attempt.
    clear_logs();
    exp_q.push_back(24'h310311);
    for (int i = 0; i < 4; i++) exp_q.push_back(24'h300882);
    nack_plan = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pulse_start();
    wait_end(2000, t);
    repeat (30) @(negedge clk);
    check("t3_err", 32'(err), 32'd1);
    check("t3_done", 32'(done), 32'd0);
    check("t3_index", 32'(reg_index), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_req_cnt", 32'(req_cnt), 32'd5);
    check("t3_exp_left", 32'(exp_q.size()), 32'd0);
`ifdef UI5640_CFG_ERRCNT_EN
    check("t3_nack_cnt", 32'(nack_cnt), 32'd4);
`endif

    // Empty table completes one cycle after start.
    clear_logs();
    reg_size = 9'd0;
    pulse_start();
    check("t4_done_next", 32'(done), 32'd1);
    check("t4_err_cleared", 32'(err), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("t4_done_sticky", 32'(done), 32'd1);
    check("t4_req_cnt", 32'(req_cnt), 32'd0);

    // Reset asserted during the software-reset wait, then a fresh pass from index 0.
    clear_logs();
    reg_size = 9'd4;
    exp_q.push_back(24'h310311);
    exp_q.push_back(24'h300882);
    pulse_start();
    n = 0;
    while (done_cyc.size() < 2 && n < 500) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("t5_busy_in_delay", 32'(busy), 32'd1);
    check("t5_req_in_delay", 32'(wr_req), 32'd0);
    check("t5_index_in_delay", 32'(reg_index), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("t5_rst_req", 32'(wr_req), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_index", 32'(reg_index), 32'd0);
    check("t5_rst_addr_data", {8'h0, wr_addr, wr_data}, 32'd0);
    check("t5_rst_flags", {30'd0, done, err}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("t5_exp_left", 32'(exp_q.size()), 32'd0);
    clear_logs();
    push_all();
    pulse_start();
    wait_end(2000, t);
    check("t5_restart_done", 32'(done), 32'd1);
    check("t5_restart_req_cnt", 32'(req_cnt), 32'd4);
    check("t5_restart_exp_left", 32'(exp_q.size()), 32'd0);

    // Start pulsed mid-pass has no effect.
    clear_logs();
    push_all();
    pulse_start();
    n = 0;
    while (req_cnt < 1 && n < 100) begin @(negedge clk); n++; end
    pulse_start();
    wait_end(2000, t);
    check("t6_done", 32'(done), 32'd1);
    check("t6_err", 32'(err), 32'd0);
    check("t6_req_cnt", 32'(req_cnt), 32'd4);
    check("t6_exp_left", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk);
    check("t6_no_restart", 32'(req_cnt), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
